// File: rtl/sm83_bus_pkg.sv
// SM83 external bus controller: shared types.
// T-state phases, bus operations and the request decoder.
package sm83_bus_pkg;

  typedef enum logic [1:0] {
    T1 = 2'd0,
    T2 = 2'd1,
    T3 = 2'd2,
    T4 = 2'd3
  } tstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } bus_op_t;

  localparam int WCNT_W = 8;

  // A read wins when both requests are raised together.
  function automatic bus_op_t decode_op(
    input logic rd,
    input logic wr
  );
    if (rd)      return RD;
    else if (wr) return WR;
    else         return IDLE;
  endfunction

endpackage

// File: rtl/sm83_bus_if.sv
// SM83 external memory bus pins.
// master = bus controller, slave = memory side.
interface sm83_bus_if #(
  parameter int ADR_WIDTH  = 16,
  parameter int DATA_WIDTH = 8
);
  logic [ADR_WIDTH-1:0]  ext_adr;
  logic [DATA_WIDTH-1:0] ext_dout;
  logic [DATA_WIDTH-1:0] ext_din;
  logic                  ext_dout_en;
  logic                  ext_cs_n;
  logic                  ext_rd_n;
  logic                  ext_wr_n;
  logic                  ext_wait;

  modport master (
    output ext_adr,
    output ext_dout,
    output ext_dout_en,
    output ext_cs_n,
    output ext_rd_n,
    output ext_wr_n,
    input  ext_din,
    input  ext_wait
  );

  modport slave (
    input  ext_adr,
    input  ext_dout,
    input  ext_dout_en,
    input  ext_cs_n,
    input  ext_rd_n,
    input  ext_wr_n,
    output ext_din,
    output ext_wait
  );
endinterface

// File: rtl/sm83_tstate_seq.sv
// SM83 T-state sequencer: T1..T4 phase counter,
// T3 stall with wait counter and forced timeout.
module sm83_tstate_seq
  import sm83_bus_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    stall_en,
  input  logic    wait_in,
  output tstate_t t_state,
  output tstate_t t_nxt,
  output logic    mcyc_end,
  output logic    timeout
);

  tstate_t             t_state_q, t_state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                mcyc_end_q, mcyc_end_d;
  logic                init_q;

  always_comb begin
    t_state_d = T1;
    wcnt_d    = wcnt_q;
    timeout   = 1'b0;
    // After reset the first edge re-enters T1 to sample a request.
    if (init_q) begin
      t_state_d = T1;
      wcnt_d    = '0;
    end else begin
      unique case (t_state_q)
        T1: t_state_d = T2;
        T2: t_state_d = T3;
        T3: begin
          t_state_d = T4;
          if (stall_en && wait_in) begin
            if (wcnt_q == WCNT_W'(WAIT_MAX)) begin
              timeout = 1'b1;
            end else begin
              t_state_d = T3;
              wcnt_d    = wcnt_q + 1'b1;
            end
          end
        end
        T4: begin
          t_state_d = T1;
          wcnt_d    = '0;
        end
      endcase
    end
    mcyc_end_d = (t_state_d == T4);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      t_state_q  <= T1;
      wcnt_q     <= '0;
      mcyc_end_q <= 1'b0;
      init_q     <= 1'b1;
    end else begin
      t_state_q  <= t_state_d;
      wcnt_q     <= wcnt_d;
      mcyc_end_q <= mcyc_end_d;
      init_q     <= 1'b0;
    end
  end

  assign t_state  = t_state_q;
  assign t_nxt    = t_state_d;
  assign mcyc_end = mcyc_end_q;

endmodule

// File: rtl/sm83_bus_ctl.sv
// SM83 external memory bus controller: one registered
// four-T-state M-cycle per request, with wait stretching.
module sm83_bus_ctl
  import sm83_bus_pkg::*;
#(
  parameter int ADR_WIDTH  = 16,
  parameter int DATA_WIDTH = 8,
  parameter int WAIT_MAX   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADR_WIDTH-1:0]  adr_in,
  input  logic                  req_rd,
  input  logic                  req_wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            t_state,
  output logic                  mcyc_end,
  output logic                  bus_err,
  sm83_bus_if.master            bus
);

  tstate_t t_cur, t_nxt;
  logic    timeout;

  bus_op_t               op_q, op_d;
  logic [ADR_WIDTH-1:0]  adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  den_q, den_d;
  logic                  cs_n_q, cs_n_d;
  logic                  rd_n_q, rd_n_d;
  logic                  wr_n_q, wr_n_d;
  logic                  err_q, err_d;

  sm83_tstate_seq #(
    .WAIT_MAX (WAIT_MAX)
  ) u_seq (
    .clk      (clk),
    .reset    (reset),
    .stall_en (op_q != IDLE),
    .wait_in  (bus.ext_wait),
    .t_state  (t_cur),
    .t_nxt    (t_nxt),
    .mcyc_end (mcyc_end),
    .timeout  (timeout)
  );

  // Outputs are set on the edge that enters each phase.
  always_comb begin
    op_d    = op_q;
    adr_d   = adr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    den_d   = den_q;
    cs_n_d  = cs_n_q;
    rd_n_d  = rd_n_q;
    wr_n_d  = wr_n_q;
    err_d   = err_q;
    unique case (t_nxt)
      T1: begin
        op_d   = decode_op(req_rd, req_wr);
        adr_d  = adr_in;
        cs_n_d = (op_d == IDLE);
        rd_n_d = 1'b1;
        wr_n_d = 1'b1;
        den_d  = 1'b0;
        if (op_d == WR)       dout_d = wdata;
        if (req_rd && req_wr) err_d  = 1'b1;
      end
      T2: begin
        rd_n_d = (op_q != RD);
        den_d  = (op_q == WR);
      end
      T3: wr_n_d = (op_q != WR);
      T4: begin
        cs_n_d = 1'b1;
        rd_n_d = 1'b1;
        wr_n_d = 1'b1;
        den_d  = 1'b0;
        if (op_q == RD)
          rdata_d = timeout ? '1 : bus.ext_din;
        if (timeout) err_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q    <= IDLE;
      adr_q   <= '0;
      dout_q  <= '0;
      rdata_q <= '1;
      den_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      op_q    <= op_d;
      adr_q   <= adr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      den_q   <= den_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      err_q   <= err_d;
    end
  end

  assign t_state         = t_cur;
  assign rdata           = rdata_q;
  assign bus_err         = err_q;
  assign bus.ext_adr     = adr_q;
  assign bus.ext_dout    = dout_q;
  assign bus.ext_dout_en = den_q;
  assign bus.ext_cs_n    = cs_n_q;
  assign bus.ext_rd_n    = rd_n_q;
  assign bus.ext_wr_n    = wr_n_q;

endmodule

// File: tb/tb_sm83_bus_ctl.sv
// Bench for sm83_bus_ctl: directed cases plus random
// M-cycles against a transaction-level bus model.
module tb_sm83_bus_ctl;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int WM = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] adr_in;
  logic          req_rd;
  logic          req_wr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic [1:0]    t_state;
  logic          mcyc_end;
  logic          bus_err;

  sm83_bus_if #(.ADR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sm83_bus_ctl #(
    .ADR_WIDTH  (AW),
    .DATA_WIDTH (DW),
    .WAIT_MAX   (WM)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .adr_in   (adr_in),
    .req_rd   (req_rd),
    .req_wr   (req_wr),
    .wdata    (wdata),
    .rdata    (rdata),
    .t_state  (t_state),
    .mcyc_end (mcyc_end),
    .bus_err  (bus_err),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dout;
  logic [DW-1:0] m_rdata;
  logic          m_err;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] snap();
    return 64'({t_state, mcyc_end, bus.ext_cs_n,
                bus.ext_rd_n, bus.ext_wr_n,
                bus.ext_dout_en, bus_err, bus.ext_adr,
                bus.ext_dout, rdata});
  endfunction

  function automatic logic [63:0] expv(
    input logic [1:0] t,
    input logic       me,
    input logic       cs,
    input logic       rd,
    input logic       wr,
    input logic       den
  );
    return 64'({t, me, cs, rd, wr, den, m_err,
                m_adr, m_dout, m_rdata});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    adr_in = AW'($urandom);
    req_rd = 1'($urandom);
    req_wr = 1'($urandom);
    wdata  = DW'($urandom);
    bus.ext_wait = 1'($urandom);
    bus.ext_din  = DW'($urandom);
  endtask

  task automatic model_reset();
    m_adr   = '0;
    m_dout  = '0;
    m_rdata = '1;
    m_err   = 1'b0;
  endtask

  // One M-cycle; s = number of T3 edges with ext_wait held.
  task automatic run_mcyc(
    input string         tag,
    input bit            rd,
    input bit            wr,
    input logic [AW-1:0] adr,
    input logic [DW-1:0] wd,
    input logic [DW-1:0] din,
    input int            s
  );
    bit is_rd, is_wr, act, tmo;
    int n;
    is_rd = rd;
    is_wr = wr && !rd;
    act   = rd || wr;
    n     = act ? ((s > WM) ? WM : s) : 0;
    tmo   = act && (s > WM);
    junk();
    adr_in = adr;
    req_rd = rd;
    req_wr = wr;
    wdata  = wd;
    tick();
    m_adr = adr;
    if (is_wr) m_dout = wd;
    if (rd && wr) m_err = 1'b1;
    check({tag, "/t1"}, snap(),
          expv(2'd0, 0, !act, 1, 1, 0));
    junk();
    tick();
    check({tag, "/t2"}, snap(),
          expv(2'd1, 0, !act, !is_rd, 1, is_wr));
    junk();
    tick();
    check({tag, "/t3"}, snap(),
          expv(2'd2, 0, !act, !is_rd, !is_wr, is_wr));
    for (int j = 0; j <= n; j++) begin
      junk();
      if (act) bus.ext_wait = (j < s);
      if (j == n) bus.ext_din = din;
      tick();
      if (j < n) begin
        check({tag, "/stall"}, snap(),
              expv(2'd2, 0, !act, !is_rd, !is_wr, is_wr));
      end else begin
        if (is_rd) m_rdata = tmo ? 8'hFF : din;
        if (tmo) m_err = 1'b1;
        check({tag, "/t4"}, snap(),
              expv(2'd3, 1, 1, 1, 1, 0));
      end
    end
  endtask

  initial begin
    reset  = 1'b0;
    req_rd = 1'b0;
    req_wr = 1'b0;
    adr_in = '0;
    wdata  = '0;
    bus.ext_din  = '0;
    bus.ext_wait = 1'b0;
    model_reset();
    tick();
    check("reset", snap(), expv(2'd0, 0, 1, 1, 1, 0));
    reset = 1'b1;

    run_mcyc("idle0", 0, 0, 16'h1234, 8'h00, 8'h00, 0);
    run_mcyc("idle1", 0, 0, 16'h4321, 8'h00, 8'h00, 0);
    run_mcyc("read", 1, 0, 16'hC123, 8'h00, 8'h5A, 0);
    run_mcyc("write", 0, 1, 16'hFF80, 8'hA5, 8'h00, 0);
    run_mcyc("stall", 1, 0, 16'h8000, 8'h00, 8'h3C, 3);
    run_mcyc("wmax", 0, 1, 16'h9000, 8'h77, 8'h00, WM);
    run_mcyc("tmo", 1, 0, 16'hA000, 8'h00, 8'h12, 20);
    run_mcyc("rd_after", 1, 0, 16'hA001, 8'h00, 8'h66, 0);

    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    run_mcyc("conflict", 1, 1, 16'hB00B, 8'h99, 8'hC3, 1);

    // Reset while a read sits in T2.
    junk();
    adr_in = 16'hD00D;
    req_rd = 1'b1;
    req_wr = 1'b0;
    tick();
    m_adr = 16'hD00D;
    check("mid/t1", snap(), expv(2'd0, 0, 0, 1, 1, 0));
    junk();
    tick();
    check("mid/t2", snap(), expv(2'd1, 0, 0, 0, 1, 0));
    junk();
    reset = 1'b0;
    tick();
    model_reset();
    check("mid/rst", snap(), expv(2'd0, 0, 1, 1, 1, 0));
    reset = 1'b1;

    for (int i = 0; i < 60; i++) begin
      int r, s;
      r = int'($urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0)
        s = int'($urandom_range(0, WM + 3));
      else
        s = int'($urandom_range(0, 2));
      run_mcyc("rand", (r == 1 || r == 4),
               (r == 2 || r == 3 || r == 4),
               AW'($urandom), DW'($urandom),
               DW'($urandom), s);
    end

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sm83_bus_ctl.md
# sm83_bus_ctl

External memory bus controller for the SM83 core, directly downstream of the address latch/incrementer. Registers the latched CPU address onto the external address pins and runs one four-T-state memory cycle (M-cycle) per request: read or write strobes, data-bus direction, read-data capture, and optional wait-state stretching with timeout. Provides the T-state phase and end-of-M-cycle pulse the sequencer uses to advance.

## Interface
- ADR_WIDTH, 16, address width; must match the address latch
- DATA_WIDTH, 8, data bus width
- WAIT_MAX, 15, max stalled T3 cycles before forced completion (1..255)

- clk  in  1  core clock; all state updates on posedge (address latch updates on negedge, so adr_in is stable at every posedge)
- reset  in  1  synchronous, active-low (0 = reset), sampled on posedge clk
- adr_in  in  ADR_WIDTH  address latch output
- req_rd  in  1  read request, sampled in T1
- req_wr  in  1  write request, sampled in T1
- wdata  in  DATA_WIDTH  write data, sampled in T1
- rdata  out  DATA_WIDTH  captured read data, held until next read completes
- t_state  out  2  current phase: 0=T1, 1=T2, 2=T3, 3=T4
- mcyc_end  out  1  high during T4 of every M-cycle, including idle ones
- bus_err  out  1  sticky; set on wait timeout or rd+wr conflict; cleared only by reset
- ext_adr  out  ADR_WIDTH  external address pins
- ext_dout  out  DATA_WIDTH  external write data
- ext_dout_en  out  1  data-bus drive enable
- ext_din  in  DATA_WIDTH  external read data
- ext_cs_n, ext_rd_n, ext_wr_n  out  1 each  active-low chip select, read and write strobes
- ext_wait  in  1  external stall request, sampled in T3

## Operation
- Phase counter runs T1→T2→T3→T4→T1 continuously; idle M-cycles also cycle and pulse mcyc_end.
- Op latched in T1: RD if req_rd, WR if req_wr only, IDLE otherwise. req_rd and req_wr both high: perform RD, ignore the write, set bus_err.
- T1: ext_adr ← adr_in (every T1, including idle); ext_dout ← wdata if WR; ext_cs_n ← 0 if RD/WR.
- T2: RD: ext_rd_n ← 0. WR: ext_dout_en ← 1.
- T3: WR: ext_wr_n ← 0. If ext_wait = 1 and op ≠ IDLE, remain in T3 and increment the wait counter. The wait counter clears on entry to T1.
- T3→T4 transition (ext_wait = 0 or timeout): RD captures rdata ← ext_din; on timeout, rdata ← all-ones and bus_err set.
- Timeout: after WAIT_MAX consecutive stalled T3 cycles, the next edge leaves T3 regardless of ext_wait.
- T4: ext_rd_n, ext_wr_n, ext_cs_n ← 1, ext_dout_en ← 0. ext_adr holds until the next T1.
- ext_wait is ignored in IDLE cycles and outside T3.

## Timing
- Reset values (one edge with reset = 0): t_state = T1, ext_adr = 0, ext_dout = 0, rdata = all-ones, ext_cs_n/rd_n/wr_n = 1, ext_dout_en = 0, mcyc_end = 0, bus_err = 0, wait count 0, op = IDLE.
- Reset mid-cycle aborts immediately: strobes deassert at that edge, no rdata capture. After reset releases, the first edge enters T1.
- All outputs are registered; no combinational path from input to output.
- Unstalled M-cycle = 4 clocks. Stalled M-cycle = 4 + n clocks, where n ≤ WAIT_MAX.
- rdata is valid from the T4 edge onward.
- mcyc_end is high exactly one clock per M-cycle.
- Strobe windows: ext_rd_n low in T2–T3; ext_wr_n low in T3 only; ext_dout_en spans T2–T3, so data is stable one clock before and during the write strobe.

## Structure
- Shared package sm83_bus_pkg: tstate_t enum (T1..T4), bus_op_t enum (IDLE, RD, WR), T-state encodings.
- One sub-module, sm83_tstate_seq: the phase counter with stall and timeout logic. It takes stall enable and WAIT_MAX, and outputs t_state, mcyc_end and a timeout pulse.

## Test plan
- Idle after reset: no requests for 8 clocks → t_state sequence 0,1,2,3,0,1,2,3; mcyc_end high on clocks 4 and 8; all strobes stay 1.
- Read: adr_in = 0xC123, req_rd in T1, ext_din = 0x5A → ext_adr = 0xC123; ext_rd_n low in T2–T3; rdata = 0x5A at T4; bus_err = 0.
- Write: adr_in = 0xFF80, wdata = 0xA5, req_wr → ext_dout = 0xA5; ext_dout_en high in T2–T3; ext_wr_n low only in T3.
- Wait stall: read with ext_wait high for 3 clocks in T3, then ext_din = 0x3C → M-cycle lasts 7 clocks; rdata = 0x3C; no error.
- Timeout: WAIT_MAX = 15, ext_wait held high → T3 lasts 16 clocks; rdata = 0xFF; bus_err = 1, still 1 after the next normal read.
- Conflict and reset: req_rd and req_wr both high → read performed, ext_wr_n stays 1, bus_err = 1. Then reset = 0 asserted in T2 of a read → strobes at 1 and t_state = T1 at that edge; rdata = 0xFF.
